// File: rtl/flp_tree_pkg.sv
// Shared constants and helpers for the floating-point adder tree.
// Number format: value = (1 + mant/2^MANT_WIDTH) * 2^(exp - BIAS), exp==0 is zero.
package flp_tree_pkg;

    localparam int DEF_NUM_INPUTS = 8;
    localparam int DEF_EXP_WIDTH  = 9;
    localparam int DEF_MANT_WIDTH = 8;

    // Bias of an exponent field of the given width (half range minus one).
    function automatic int bias_for(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    localparam int BIAS = bias_for(DEF_EXP_WIDTH);

    // Ceiling log2; number of pairwise-reduction levels for n operands.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of live elements after lvl pairwise reductions of n operands.
    function automatic int level_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Bit offset of element i inside the packed input bus.
    function automatic int elem_lsb(input int i, input int ew, input int mw);
        return i * (ew + mw);
    endfunction

    // Bit offset of the exponent field of element i (exponent sits above mantissa).
    function automatic int exp_lsb(input int i, input int ew, input int mw);
        return i * (ew + mw) + mw;
    endfunction

endpackage

// File: rtl/flp_add_stage.sv
// One registered two-operand add: align the smaller operand to the larger
// exponent, add with truncation, renormalise on carry, saturate on exponent
// overflow. A zero operand (exp==0) passes the other operand through, so an
// unpaired element can use this stage as a plain pipeline register.
module flp_add_stage
    import flp_tree_pkg::*;
#(
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int MANT_WIDTH = DEF_MANT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance_i,
    input  logic                  valid_i,
    input  logic [EXP_WIDTH-1:0]  a_exp_i,
    input  logic [MANT_WIDTH-1:0] a_mant_i,
    input  logic                  a_ovf_i,
    input  logic [EXP_WIDTH-1:0]  b_exp_i,
    input  logic [MANT_WIDTH-1:0] b_mant_i,
    input  logic                  b_ovf_i,
    output logic                  valid_o,
    output logic [EXP_WIDTH-1:0]  exp_o,
    output logic [MANT_WIDTH-1:0] mant_o,
    output logic                  ovf_o
);

    localparam logic [EXP_WIDTH-1:0]  EXP_MAX     = {EXP_WIDTH{1'b1}};
    localparam logic [MANT_WIDTH-1:0] MANT_MAX    = {MANT_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0]  EXP_ZERO    = {EXP_WIDTH{1'b0}};
    localparam logic [MANT_WIDTH-1:0] MANT_ZERO   = {MANT_WIDTH{1'b0}};
    localparam logic [EXP_WIDTH-1:0]  EXP_ONE     = {{(EXP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EXP_WIDTH-1:0]  SHIFT_LIMIT = EXP_WIDTH'(MANT_WIDTH);

    logic                  swap_s;
    logic [EXP_WIDTH-1:0]  big_exp_s;
    logic [EXP_WIDTH-1:0]  small_exp_s;
    logic [MANT_WIDTH-1:0] big_mant_s;
    logic [MANT_WIDTH-1:0] small_mant_s;
    logic [EXP_WIDTH-1:0]  diff_s;
    logic [MANT_WIDTH:0]   small_sig_s;
    logic [MANT_WIDTH:0]   small_sh_s;
    logic [MANT_WIDTH+1:0] sum_s;

    logic [EXP_WIDTH-1:0]  exp_d;
    logic [MANT_WIDTH-1:0] mant_d;
    logic                  ovf_d;

    logic                  valid_q;
    logic [EXP_WIDTH-1:0]  exp_q;
    logic [MANT_WIDTH-1:0] mant_q;
    logic                  ovf_q;

    // Combinational align / add / normalise of the two operands.
    always_comb begin
        swap_s       = (b_exp_i > a_exp_i);
        big_exp_s    = swap_s ? b_exp_i  : a_exp_i;
        big_mant_s   = swap_s ? b_mant_i : a_mant_i;
        small_exp_s  = swap_s ? a_exp_i  : b_exp_i;
        small_mant_s = swap_s ? a_mant_i : b_mant_i;
        diff_s       = big_exp_s - small_exp_s;
        small_sig_s  = {1'b1, small_mant_s};
        small_sh_s   = small_sig_s >> diff_s;
        sum_s        = {1'b0, 1'b1, big_mant_s} + {1'b0, small_sh_s};
        exp_d        = big_exp_s;
        mant_d       = big_mant_s;
        ovf_d        = a_ovf_i | b_ovf_i;

        if ((a_exp_i == EXP_ZERO) && (b_exp_i == EXP_ZERO)) begin
            exp_d  = EXP_ZERO;
            mant_d = MANT_ZERO;
        end else if (a_exp_i == EXP_ZERO) begin
            exp_d  = b_exp_i;
            mant_d = b_mant_i;
        end else if (b_exp_i == EXP_ZERO) begin
            exp_d  = a_exp_i;
            mant_d = a_mant_i;
        end else if (diff_s > SHIFT_LIMIT) begin
            // Smaller operand would be shifted out entirely.
            exp_d  = big_exp_s;
            mant_d = big_mant_s;
        end else if (sum_s[MANT_WIDTH+1]) begin
            if (big_exp_s == EXP_MAX) begin
                exp_d  = EXP_MAX;
                mant_d = MANT_MAX;
                ovf_d  = 1'b1;
            end else begin
                exp_d  = big_exp_s + EXP_ONE;
                mant_d = sum_s[MANT_WIDTH:1];
            end
        end else begin
            exp_d  = big_exp_s;
            mant_d = sum_s[MANT_WIDTH-1:0];
        end
    end

    // Result register; holds whenever the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            exp_q   <= EXP_ZERO;
            mant_q  <= MANT_ZERO;
            ovf_q   <= 1'b0;
        end else if (advance_i) begin
            valid_q <= valid_i;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign exp_o   = exp_q;
    assign mant_o  = mant_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/flp_acc_tree.sv
// Pipelined pairwise adder tree for NUM_INPUTS unsigned floating-point operands.
// One register level per reduction level; all levels advance together when the
// output is empty or being consumed. Define FLP_TREE_ACC_EN to add a frame
// accumulator after the tree (one result per in_last-tagged beat).
module flp_acc_tree
    import flp_tree_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int MANT_WIDTH = DEF_MANT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       in_last,
    input  logic [NUM_INPUTS*(EXP_WIDTH+MANT_WIDTH)-1:0] in_bus,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [EXP_WIDTH-1:0]                       out_exp,
    output logic [MANT_WIDTH-1:0]                      out_mant,
    output logic                                       out_ovf
);

    localparam int LEVELS = clog2(NUM_INPUTS);

    logic                  advance_s;
    logic [EXP_WIDTH-1:0]  exp_s  [0:LEVELS][0:NUM_INPUTS-1];
    logic [MANT_WIDTH-1:0] mant_s [0:LEVELS][0:NUM_INPUTS-1];
    logic                  ovf_s  [0:LEVELS][0:NUM_INPUTS-1];
    logic [NUM_INPUTS-1:0] vld_s  [0:LEVELS];

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign exp_s[0][i]  = in_bus[exp_lsb(i, EXP_WIDTH, MANT_WIDTH) +: EXP_WIDTH];
        assign mant_s[0][i] = in_bus[elem_lsb(i, EXP_WIDTH, MANT_WIDTH) +: MANT_WIDTH];
        assign ovf_s[0][i]  = 1'b0;
        assign vld_s[0][i]  = in_valid;
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int PREV = level_count(NUM_INPUTS, l - 1);
        localparam int CUR  = level_count(NUM_INPUTS, l);
        logic lvl_valid_s;
        // Unused slots are tied to 1, so the AND is the level's valid.
        assign lvl_valid_s = &vld_s[l-1];
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_el
            if (i < CUR) begin : g_used
                logic [EXP_WIDTH-1:0]  b_exp_s;
                logic [MANT_WIDTH-1:0] b_mant_s;
                logic                  b_ovf_s;
                if (2 * i + 1 < PREV) begin : g_pair
                    assign b_exp_s  = exp_s[l-1][2*i+1];
                    assign b_mant_s = mant_s[l-1][2*i+1];
                    assign b_ovf_s  = ovf_s[l-1][2*i+1];
                end else begin : g_pass
                    // Unpaired element: adding a zero keeps it unchanged.
                    assign b_exp_s  = {EXP_WIDTH{1'b0}};
                    assign b_mant_s = {MANT_WIDTH{1'b0}};
                    assign b_ovf_s  = 1'b0;
                end
                flp_add_stage #(
                    .EXP_WIDTH (EXP_WIDTH),
                    .MANT_WIDTH(MANT_WIDTH)
                ) u_add (
                    .clk      (clk),
                    .rst      (rst),
                    .advance_i(advance_s),
                    .valid_i  (lvl_valid_s),
                    .a_exp_i  (exp_s[l-1][2*i]),
                    .a_mant_i (mant_s[l-1][2*i]),
                    .a_ovf_i  (ovf_s[l-1][2*i]),
                    .b_exp_i  (b_exp_s),
                    .b_mant_i (b_mant_s),
                    .b_ovf_i  (b_ovf_s),
                    .valid_o  (vld_s[l][i]),
                    .exp_o    (exp_s[l][i]),
                    .mant_o   (mant_s[l][i]),
                    .ovf_o    (ovf_s[l][i])
                );
            end else begin : g_idle
                assign vld_s[l][i]  = 1'b1;
                assign exp_s[l][i]  = {EXP_WIDTH{1'b0}};
                assign mant_s[l][i] = {MANT_WIDTH{1'b0}};
                assign ovf_s[l][i]  = 1'b0;
            end
        end
    end

`ifdef FLP_TREE_ACC_EN
    logic [LEVELS-1:0]     last_q;
    logic                  pend_q;
    logic                  tree_valid_s;
    logic                  tree_last_s;
    logic [EXP_WIDTH-1:0]  a_exp_s;
    logic [MANT_WIDTH-1:0] a_mant_s;
    logic                  a_ovf_s;
    logic [EXP_WIDTH-1:0]  fb_exp_s;
    logic [MANT_WIDTH-1:0] fb_mant_s;
    logic                  fb_ovf_s;

    assign tree_valid_s = &vld_s[LEVELS];
    assign tree_last_s  = last_q[LEVELS-1];

    // Carry the frame-end tag alongside the data through the tree levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= {LEVELS{1'b0}};
        end else if (advance_s) begin
            last_q[0] <= in_last;
            for (int l = 1; l < LEVELS; l++) begin
                last_q[l] <= last_q[l-1];
            end
        end
    end

    // Tracks whether the accumulator register holds a partial frame sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else if (advance_s && tree_valid_s) begin
            pend_q <= !tree_last_s;
        end
    end

    // Select accumulator operands: bubbles add zero, a closed frame restarts from zero.
    always_comb begin
        a_exp_s   = {EXP_WIDTH{1'b0}};
        a_mant_s  = {MANT_WIDTH{1'b0}};
        a_ovf_s   = 1'b0;
        fb_exp_s  = {EXP_WIDTH{1'b0}};
        fb_mant_s = {MANT_WIDTH{1'b0}};
        fb_ovf_s  = 1'b0;
        if (tree_valid_s) begin
            a_exp_s  = exp_s[LEVELS][0];
            a_mant_s = mant_s[LEVELS][0];
            a_ovf_s  = ovf_s[LEVELS][0];
        end else begin
            a_exp_s  = {EXP_WIDTH{1'b0}};
        end
        if (pend_q) begin
            fb_exp_s  = out_exp;
            fb_mant_s = out_mant;
            fb_ovf_s  = out_ovf;
        end else begin
            fb_exp_s  = {EXP_WIDTH{1'b0}};
        end
    end

    flp_add_stage #(
        .EXP_WIDTH (EXP_WIDTH),
        .MANT_WIDTH(MANT_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .advance_i(advance_s),
        .valid_i  (tree_valid_s && tree_last_s),
        .a_exp_i  (a_exp_s),
        .a_mant_i (a_mant_s),
        .a_ovf_i  (a_ovf_s),
        .b_exp_i  (fb_exp_s),
        .b_mant_i (fb_mant_s),
        .b_ovf_i  (fb_ovf_s),
        .valid_o  (out_valid),
        .exp_o    (out_exp),
        .mant_o   (out_mant),
        .ovf_o    (out_ovf)
    );
`else
    assign out_valid = &vld_s[LEVELS];
    assign out_exp   = exp_s[LEVELS][0];
    assign out_mant  = mant_s[LEVELS][0];
    assign out_ovf   = ovf_s[LEVELS][0];
`endif

endmodule

// File: tb/tb_flp_acc_tree.sv
// Self-checking bench for flp_acc_tree (NUM_INPUTS=4, EXP_WIDTH=5, MANT_WIDTH=4)
// plus a NUM_INPUTS=5 instance for the odd-count and reset-discard cases.
module tb_flp_acc_tree;

    localparam int NI     = 4;
    localparam int EW     = 5;
    localparam int MW     = 4;
    localparam int W      = EW + MW;
    localparam int LEVELS = 2;
`ifdef FLP_TREE_ACC_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif
    localparam int LAT  = LEVELS + ACC;
    localparam int LAT5 = 3 + ACC;
    localparam int EMAX = 31;
    localparam int MMAX = 15;
    localparam int ONE  = 16;

    typedef struct { int e; int m; bit o; } fv_t;
    typedef struct { fv_t v; int acc_cyc; bit chk; } exp_t;

    logic clk, rst;
    logic in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [NI*W-1:0] in_bus;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_mant;

    logic rst5, in_valid5, in_ready5, in_last5, out_valid5, out_ready5, out_ovf5;
    logic [5*W-1:0] in_bus5;
    logic [EW-1:0] out_exp5;
    logic [MW-1:0] out_mant5;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit rnd_ready = 0;
    exp_t sb_q[$];
    fv_t acc_m;
    int el_e[NI], el_m[NI];

    flp_acc_tree #(.NUM_INPUTS(NI), .EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_bus(in_bus), .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_mant(out_mant), .out_ovf(out_ovf));

    flp_acc_tree #(.NUM_INPUTS(5), .EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut5 (
        .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_ready(in_ready5), .in_last(in_last5),
        .in_bus(in_bus5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_exp(out_exp5), .out_mant(out_mant5), .out_ovf(out_ovf5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp = n_cmp + 1;
        if (act != req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference add on real significands: value = sig/16 * 2^e, sig in [16,32).
    function automatic fv_t ref_add(input fv_t a, input fv_t b);
        fv_t big, sm, r;
        int d, s;
        r.o = a.o | b.o;
        if (a.e == 0 && b.e == 0) begin r.e = 0; r.m = 0; return r; end
        if (a.e == 0) begin r.e = b.e; r.m = b.m; return r; end
        if (b.e == 0) begin r.e = a.e; r.m = a.m; return r; end
        if (a.e >= b.e) begin big = a; sm = b; end else begin big = b; sm = a; end
        d = big.e - sm.e;
        if (d > MW) begin r.e = big.e; r.m = big.m; return r; end
        s = (ONE + big.m) + ((ONE + sm.m) >> d);
        r.e = big.e;
        if (s >= 2 * ONE) begin
            s = s / 2;
            r.e = r.e + 1;
        end
        if (r.e > EMAX) begin r.e = EMAX; r.m = MMAX; r.o = 1'b1; return r; end
        r.m = s - ONE;
        return r;
    endfunction

    // Reduce the element list level by level, pairing neighbours.
    function automatic fv_t ref_tree();
        fv_t cur[$], nxt[$], t;
        for (int i = 0; i < NI; i++) begin
            t.e = el_e[i]; t.m = el_m[i]; t.o = 1'b0;
            cur.push_back(t);
        end
        while (cur.size() > 1) begin
            nxt.delete();
            for (int i = 0; i < cur.size(); i += 2) begin
                if (i + 1 < cur.size()) nxt.push_back(ref_add(cur[i], cur[i+1]));
                else nxt.push_back(cur[i]);
            end
            cur = nxt;
        end
        return cur[0];
    endfunction

    task automatic set_elems(input int e0, m0, e1, m1, e2, m2, e3, m3);
        el_e[0] = e0; el_m[0] = m0; el_e[1] = e1; el_m[1] = m1;
        el_e[2] = e2; el_m[2] = m2; el_e[3] = e3; el_m[3] = m3;
    endtask

    task automatic rand_elems();
        for (int i = 0; i < NI; i++) begin
            case ($urandom_range(0, 9))
                0: el_e[i] = 0;
                1: el_e[i] = 31;
                2: el_e[i] = 30;
                default: el_e[i] = $urandom_range(8, 16);
            endcase
            el_m[i] = $urandom_range(0, 15);
        end
    endtask

    // Present one beat, wait for acceptance, record the expected result.
    task automatic send_beat(input bit last, input bit lat);
        logic [NI*W-1:0] bus;
        fv_t t;
        exp_t x;
        int n;
        for (int i = 0; i < NI; i++) bus[i*W +: W] = {5'(el_e[i]), 4'(el_m[i])};
        t = ref_tree();
        in_bus = bus; in_last = last; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
        end else begin
`ifdef FLP_TREE_ACC_EN
            acc_m = ref_add(acc_m, t);
            if (last) begin
                x.v = acc_m; x.acc_cyc = cyc; x.chk = lat;
                sb_q.push_back(x);
                acc_m = '{0, 0, 1'b0};
            end
`else
            x.v = t; x.acc_cyc = cyc; x.chk = lat;
            sb_q.push_back(x);
`endif
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pop on each new output, verify freezing while stalled.
    initial begin
        bit held;
        int sv_e, sv_m, sv_o;
        exp_t x;
        held = 0; sv_e = 0; sv_m = 0; sv_o = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
                if (out_valid) begin
                    if (held) begin
                        chk("hold_exp", out_exp, sv_e);
                        chk("hold_mant", out_mant, sv_m);
                        chk("hold_ovf", out_ovf, sv_o);
                    end else if (sb_q.size() == 0) begin
                        chk("unexpected_output_sb_size", sb_q.size(), 1);
                    end else begin
                        x = sb_q.pop_front();
                        chk("out_exp", out_exp, x.v.e);
                        chk("out_mant", out_mant, x.v.m);
                        chk("out_ovf", out_ovf, x.v.o);
                        if (x.chk) chk("latency", cyc - x.acc_cyc, LAT);
                    end
                    sv_e = out_exp; sv_m = out_mant; sv_o = out_ovf;
                    held = !out_ready;
                end else begin
                    if (held) chk("dropped_during_stall", out_valid, 1);
                    held = 0;
                end
            end
        end
    end

    // Random back-pressure when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int n, c0;
        bit seen;
        rst = 1'b1; rst5 = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_bus = '0; out_ready = 1'b1;
        in_valid5 = 1'b0; in_last5 = 1'b1; in_bus5 = '0; out_ready5 = 1'b1;
        acc_m = '{0, 0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_exp", out_exp, 0);
        chk("rst_out_mant", out_mant, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst5_out_valid", out_valid5, 0);
        @(posedge clk); #1;
        rst = 1'b0; rst5 = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Directed cases, no back-pressure, latency checked.
        set_elems(10, 0, 10, 0, 10, 0, 10, 0);  send_beat(1'b1, 1'b1);
        set_elems(10, 8, 10, 8, 0, 0, 0, 0);    send_beat(1'b1, 1'b1);
        set_elems(16, 0, 10, 15, 0, 0, 0, 0);   send_beat(1'b1, 1'b1);
        set_elems(31, 15, 31, 15, 31, 15, 31, 15); send_beat(1'b1, 1'b1);
`ifdef FLP_TREE_ACC_EN
        set_elems(10, 0, 10, 0, 10, 0, 10, 0);  send_beat(1'b0, 1'b0);
        send_beat(1'b1, 1'b1);
`endif
        repeat (6) @(posedge clk); #1;

        // Streaming with a 3-cycle consumer stall.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    rand_elems();
                    send_beat(1'b1, 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        // Random traffic with random back-pressure and frame boundaries.
        rnd_ready = 1;
        for (int k = 0; k < 200; k++) begin
            rand_elems();
            send_beat($urandom_range(0, 2) == 0, 1'b0);
        end
        rand_elems();
        send_beat(1'b1, 1'b0);
        rnd_ready = 0;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("drain_sb_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("idle_out_valid", out_valid, 0);

        // Odd operand count: pass-through element and latency 3 (+acc).
        for (int i = 0; i < 5; i++) in_bus5[i*W +: W] = {5'd10, 4'd0};
        @(posedge clk); #1;
        in_valid5 = 1'b1;
        @(negedge clk);
        chk("n5_in_ready", in_ready5, 1);
        c0 = cyc;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid5 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("n5_out_valid", out_valid5, 1);
        chk("n5_latency", cyc - c0, LAT5);
        chk("n5_exp", out_exp5, 12);
        chk("n5_mant", out_mant5, 4);
        chk("n5_ovf", out_ovf5, 0);

        // Reset one cycle after acceptance discards the beat.
        @(posedge clk); #1;
        in_valid5 = 1'b1;
        @(negedge clk);
        chk("n5_in_ready2", in_ready5, 1);
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        @(posedge clk); #1;
        rst5 = 1'b1;
        @(negedge clk);
        chk("n5_rst_valid", out_valid5, 0);
        chk("n5_rst_exp", out_exp5, 0);
        @(posedge clk); #1;
        rst5 = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid5) seen = 1;
        end
        chk("n5_no_partial_after_rst", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
